// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings and fill bytes.
// Optional IMEM_NOP_PREFIX_EN is consumed by imem_loader, not here.
package imem_pkg;

  localparam int unsigned MEM_BYTES_DEF   = 256;
  localparam int unsigned INSTR_BYTES_DEF = 10;

  localparam logic [7:0] NOP_BYTE  = 8'h10;
  localparam logic [7:0] HALT_BYTE = 8'h00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_RUN   = 3'd3;
  localparam state_t ST_OVF   = 3'd4;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-addressed instruction storage: one synchronous write port and a
// combinational INSTR_BYTES-wide fetch window, zero-filled past the end of memory.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF,
  localparam int unsigned AW         = $clog2(MEM_BYTES),
  localparam int unsigned IW         = INSTR_BYTES * 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [63:0]   rd_addr,
  output logic [IW-1:0] window
);

  logic [7:0] mem [MEM_BYTES];

  // Contents survive reset on purpose; the loader masks them while held.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Byte k of the window lands big-endian: rd_addr+0 in the top byte.
  always_comb begin
    window = '0;
    for (int k = 0; k < int'(INSTR_BYTES); k++) begin
      if ((rd_addr + 64'(k)) < 64'(MEM_BYTES)) begin
        window[IW-8-8*k +: 8] = mem[AW'(rd_addr + 64'(k))];
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader for the Y86-64 instruction memory; holds the core
// until a load completes. Define IMEM_NOP_PREFIX_EN to reserve address 0 for a nop.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = MEM_BYTES_DEF,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF,
  localparam int unsigned IW         = INSTR_BYTES * 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          ld_overflow,
  output logic [8:0]    ld_count,
  output logic          cpu_hold,
  input  logic [63:0]   f_PC,
  output logic [IW-1:0] instr,
  output logic          imem_error
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned PW = AW + 1;

`ifdef IMEM_NOP_PREFIX_EN
  localparam logic [PW-1:0] BASE       = PW'(1);
  localparam logic [7:0]    ADDR0_BYTE = NOP_BYTE;
`else
  localparam logic [PW-1:0] BASE       = PW'(0);
  localparam logic [7:0]    ADDR0_BYTE = HALT_BYTE;
`endif

  localparam logic [IW-1:0] HOLD_WORD = {NOP_BYTE, {(IW-8){1'b0}}};

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] clr_cnt;
  logic [PW-1:0] ptr;
  logic          store_c;
  logic          clearing_c;
  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [7:0]    wdata_c;
  logic [IW-1:0] window;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a byte offered with the pointer past the end is dropped
  always_comb begin
    state_nx = state;
    store_c  = 1'b0;
    case (state)
      ST_IDLE, ST_RUN, ST_OVF: begin
        if (ld_start) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt == AW'(MEM_BYTES - 1)) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_valid && ld_ready) begin
          if (ptr == PW'(MEM_BYTES)) begin
            state_nx = ST_OVF;
          end else begin
            store_c = 1'b1;
            if (ld_last) state_nx = ST_RUN;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counters and registered status, all decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt     <= '0;
      ptr         <= '0;
      ld_count    <= '0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      ld_overflow <= 1'b0;
      cpu_hold    <= 1'b1;
    end else begin
      ld_ready    <= (state_nx == ST_LOAD);
      ld_done     <= (state_nx == ST_RUN);
      ld_overflow <= (state_nx == ST_OVF);
      cpu_hold    <= (state_nx != ST_RUN);
      if (state != ST_CLEAR && state_nx == ST_CLEAR) begin
        clr_cnt  <= '0;
        ptr      <= BASE;
        ld_count <= '0;
      end else if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + AW'(1);
      end else if (store_c) begin
        ptr      <= ptr + PW'(1);
        ld_count <= ld_count + 9'(1);
      end
    end
  end

  // Memory write port: clear walk or accepted program byte
  always_comb begin
    clearing_c = (state == ST_CLEAR);
    we_c       = clearing_c || store_c;
    waddr_c    = clearing_c ? clr_cnt : ptr[AW-1:0];
    if (clearing_c) begin
      wdata_c = (clr_cnt == '0) ? ADDR0_BYTE : HALT_BYTE;
    end else begin
      wdata_c = ld_data;
    end
  end

  imem_byte_array #(
    .MEM_BYTES   (MEM_BYTES),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_array (
    .clk     (clk),
    .we      (we_c),
    .waddr   (waddr_c),
    .wdata   (wdata_c),
    .rd_addr (f_PC),
    .window  (window)
  );

  assign imem_error = (f_PC >= 64'(MEM_BYTES));

  // A held core sees a nop so a stalled fetch cannot misbehave
  assign instr = cpu_hold   ? HOLD_WORD :
                 imem_error ? '0        : window;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads with expectations queued by
// the driver and checked by a separate monitor. Follows IMEM_NOP_PREFIX_EN if defined.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned MEM_BYTES = 256;
`ifdef IMEM_NOP_PREFIX_EN
  localparam int unsigned BASE = 1;
`else
  localparam int unsigned BASE = 0;
`endif
  localparam int unsigned CAP = MEM_BYTES - BASE;
  localparam logic [79:0] NOP_WORD = {NOP_BYTE, 72'h0};

  localparam int K_INSTR = 0;
  localparam int K_ERR   = 1;
  localparam int K_COUNT = 2;
  localparam int K_DONE  = 3;
  localparam int K_OVF   = 4;
  localparam int K_HOLD  = 5;
  localparam int K_READY = 6;
  localparam int K_TOP   = 7;

  logic        clk;
  logic        reset;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_overflow;
  logic [8:0]  ld_count;
  logic        cpu_hold;
  logic [63:0] f_PC;
  logic [79:0] instr;
  logic        imem_error;

  logic        chk_req;
  int          checks;
  int          failures;

  int          kind_q[$];
  logic [79:0] exp_q[$];
  string       name_q[$];

  imem_loader #(.MEM_BYTES(MEM_BYTES), .INSTR_BYTES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .ld_overflow (ld_overflow),
    .ld_count    (ld_count),
    .cpu_hold    (cpu_hold),
    .f_PC        (f_PC),
    .instr       (instr),
    .imem_error  (imem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] observe(input int kind);
    case (kind)
      K_INSTR: return instr;
      K_ERR:   return 80'(imem_error);
      K_COUNT: return 80'(ld_count);
      K_DONE:  return 80'(ld_done);
      K_OVF:   return 80'(ld_overflow);
      K_HOLD:  return 80'(cpu_hold);
      K_READY: return 80'(ld_ready);
      K_TOP:   return 80'(instr[79:72]);
      default: return 'x;
    endcase
  endfunction

  // Monitor: drains every queued expectation when the driver presents a sample point
  always @(negedge clk) begin
    int          k;
    logic [79:0] e;
    logic [79:0] act;
    string       nm;
    if (chk_req) begin
      while (kind_q.size() > 0) begin
        k   = kind_q.pop_front();
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = observe(k);
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [79:0] v, input string nm);
    kind_q.push_back(kind);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic check_now();
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // Issues ld_start, optionally with ld_valid held through the whole clear
  task automatic start_load(input logic hold_valid);
    ld_valid = hold_valid;
    ld_data  = 8'hEE;
    ld_start = 1'b1;
    tick(1);
    ld_start = 1'b0;
    expect_val(K_COUNT, 80'd0, "clear_count");
    expect_val(K_OVF,   80'd0, "clear_ovf");
    expect_val(K_HOLD,  80'd1, "clear_hold");
    expect_val(K_READY, 80'd0, "clear_ready");
    check_now();
    tick(MEM_BYTES - 1);
    expect_val(K_READY, 80'd0, "ready_before_end");
    expect_val(K_COUNT, 80'd0, "no_accept_in_clear");
    check_now();
    tick(1);
    expect_val(K_READY, 80'd1, "ready_after_clear");
    expect_val(K_COUNT, 80'd0, "count_at_load");
    check_now();
    ld_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    int n;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick(gap);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    n = 0;
    while (!ld_ready && n < 600) begin
      tick(1);
      n++;
    end
    checks++;
    if (!ld_ready) begin
      failures++;
      $display("FAIL ready_timeout: got ld_ready=%0b expected 1", ld_ready);
    end
    tick(1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  prog [11];
    logic [79:0] exp_w;
    prog = '{8'h30, 8'hF2, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    checks = 0;
    failures = 0;
    chk_req = 1'b0;
    ld_data = 8'h00;
    f_PC = 64'd0;
    do_reset();

    // Reset state
    expect_val(K_HOLD,  80'd1, "rst_hold");
    expect_val(K_READY, 80'd0, "rst_ready");
    expect_val(K_DONE,  80'd0, "rst_done");
    expect_val(K_OVF,   80'd0, "rst_ovf");
    expect_val(K_COUNT, 80'd0, "rst_count");
    expect_val(K_INSTR, NOP_WORD, "rst_instr");
    expect_val(K_ERR,   80'd0, "rst_err_pc0");
    check_now();
    f_PC = 64'd300;
    expect_val(K_ERR,   80'd1, "rst_err_pc300");
    expect_val(K_INSTR, NOP_WORD, "rst_instr_pc300");
    check_now();

    // Program load with ld_valid held in CLEAR and random gaps in LOAD
    start_load(1'b1);
    for (int i = 0; i < 10; i++) send_byte(prog[i], 1'b0, int'($urandom_range(0, 2)));
    f_PC = 64'(BASE);
    expect_val(K_COUNT, 80'd10, "load_count_10");
    expect_val(K_HOLD,  80'd1, "load_still_held");
    expect_val(K_INSTR, NOP_WORD, "load_instr_held");
    check_now();
    send_byte(prog[10], 1'b1, int'($urandom_range(0, 2)));
    expect_val(K_COUNT, 80'd11, "load_count_11");
    expect_val(K_DONE,  80'd1, "load_done");
    expect_val(K_HOLD,  80'd0, "load_released");
    expect_val(K_READY, 80'd0, "load_ready_run");
    expect_val(K_INSTR, 80'h30F2_0500_0000_0000_0000, "load_instr_base");
    check_now();
    f_PC = 64'(BASE + 1);
    expect_val(K_INSTR, 80'hF205_0000_0000_0000_0000, "load_instr_base1");
    check_now();
    f_PC = 64'd0;
    expect_val(K_TOP, (BASE == 1) ? 80'h10 : 80'h30, "load_addr0");
    check_now();

    // Overflow: fill to capacity, then one more byte
    start_load(1'b0);
    for (int i = 0; i < int'(CAP); i++) send_byte(8'h55, 1'b0, 0);
    expect_val(K_COUNT, 80'(CAP), "full_count");
    expect_val(K_READY, 80'd1, "full_ready");
    expect_val(K_OVF,   80'd0, "full_no_ovf");
    check_now();
    send_byte(8'h66, 1'b0, 0);
    f_PC = 64'(BASE);
    expect_val(K_OVF,   80'd1, "ovf_flag");
    expect_val(K_COUNT, 80'(CAP), "ovf_count");
    expect_val(K_HOLD,  80'd1, "ovf_hold");
    expect_val(K_READY, 80'd0, "ovf_ready");
    expect_val(K_DONE,  80'd0, "ovf_done");
    expect_val(K_INSTR, NOP_WORD, "ovf_instr");
    check_now();

    // Exact-capacity load with ld_last on the final byte, then window edge
    start_load(1'b0);
    for (int i = 0; i < int'(CAP); i++) send_byte(8'hAA, (i == int'(CAP) - 1), 0);
    f_PC = 64'd250;
    expect_val(K_DONE,  80'd1, "cap_done");
    expect_val(K_OVF,   80'd0, "cap_no_ovf");
    expect_val(K_COUNT, 80'(CAP), "cap_count");
    expect_val(K_INSTR, 80'hAAAA_AAAA_AAAA_0000_0000, "edge_pc250");
    expect_val(K_ERR,   80'd0, "edge_err250");
    check_now();
    f_PC = 64'd255;
    expect_val(K_INSTR, 80'hAA00_0000_0000_0000_0000, "edge_pc255");
    expect_val(K_ERR,   80'd0, "edge_err255");
    check_now();
    f_PC = 64'd256;
    expect_val(K_INSTR, 80'h0, "edge_pc256");
    expect_val(K_ERR,   80'd1, "edge_err256");
    check_now();

    // Reset in the middle of a load, then reload over stale bytes
    start_load(1'b0);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 1);
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b0, 2);
    send_byte(8'h55, 1'b0, 0);
    expect_val(K_COUNT, 80'd5, "mid_count5");
    check_now();
    do_reset();
    f_PC = 64'd3;
    expect_val(K_HOLD,  80'd1, "mid_rst_hold");
    expect_val(K_COUNT, 80'd0, "mid_rst_count");
    expect_val(K_READY, 80'd0, "mid_rst_ready");
    expect_val(K_DONE,  80'd0, "mid_rst_done");
    expect_val(K_INSTR, NOP_WORD, "mid_rst_instr");
    check_now();
    start_load(1'b0);
    send_byte(8'h77, 1'b1, 0);
    expect_val(K_DONE,  80'd1, "reload_done");
    expect_val(K_COUNT, 80'd1, "reload_count");
    expect_val(K_INSTR, 80'h0, "reload_addr3_cleared");
    check_now();
    f_PC = 64'd0;
    exp_w = (BASE == 1) ? {8'h10, 8'h77, 64'h0} : {8'h77, 72'h0};
    expect_val(K_INSTR, exp_w, "reload_pc0");
    check_now();

    tick(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory writer for the pipelined Y86-64 core. It accepts a byte-serial program stream over a valid/ready handshake and writes it into a byte-addressed instruction memory. It holds the core in fetch stall while loading, then serves the 10-byte instruction window that the fetch stage reads at `f_PC`. It sits between the testbench or host program source and the fetch stage, in place of a `$readmemb` preload.

## Interface
Parameters:
- `MEM_BYTES`, 256: instruction memory size in bytes.
- `INSTR_BYTES`, 10: width of the fetch window in bytes.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `ld_start`  in  1: request a new load; the memory is cleared first.
- `ld_valid`  in  1: `ld_data` is valid.
- `ld_data`  in  8: program byte.
- `ld_last`  in  1: qualifies the final byte of the program.
- `ld_ready`  out  1: loader can accept a byte.
- `ld_done`  out  1: level; a program is loaded and the core is running.
- `ld_overflow`  out  1: level; the program exceeded memory capacity.
- `ld_count`  out  9: count of accepted bytes in the current load.
- `cpu_hold`  out  1: drives the core's F/D stall.
- `f_PC`  in  64: fetch address.
- `instr`  out  80: bytes `f_PC`..`f_PC+9`; the byte at `f_PC` is in `[79:72]`.
- `imem_error`  out  1: `f_PC` >= `MEM_BYTES`.

## Operation
- FSM states:
  - IDLE: after reset.
  - CLEAR: memory fill.
  - LOAD: accepting bytes.
  - RUN: core released.
  - OVF: capacity error.
- IDLE or RUN or OVF with `ld_start` -> CLEAR.
  - `ld_start` is ignored in CLEAR and LOAD.
  - Entering CLEAR zeroes `ld_count`, `ld_done` and `ld_overflow`.
- CLEAR:
  - A clear counter walks addresses 0..`MEM_BYTES`-1, writing one byte per cycle.
  - Every address is written 0x00 (halt), except address 0, which is written per Configuration.
  - After the last address -> LOAD.
- LOAD:
  - `ld_ready`=1.
  - Write pointer starts at `BASE` (see Configuration).
  - On `ld_valid`&&`ld_ready`: write `ld_data` at the pointer, then pointer++ and `ld_count`++.
  - An accepted byte with `ld_last`=1 -> RUN.
- Overflow:
  - If a byte is offered while the pointer == `MEM_BYTES`, the byte is dropped and the state goes to OVF.
  - `ld_count` is not incremented and `ld_overflow`=1.
  - Offering the byte at address `MEM_BYTES`-1 together with `ld_last` is legal and goes to RUN.
- `cpu_hold`=1 in every state except RUN. `ld_done`=1 only in RUN.
- Read port (combinational):
  - While `cpu_hold`=1, `instr` = {0x10, 72'h0}, a nop, so a stalled fetch is harmless.
  - Otherwise each window byte is mem[`f_PC`+k], or 0x00 if that address is >= `MEM_BYTES`.
  - `imem_error`=1 iff `f_PC` >= `MEM_BYTES`, regardless of state; `instr` is 0 in that case when not held.
- Reset mid-operation (any state) -> IDLE. Memory contents are retained but never exposed, because hold=1.

## Timing
- Reset values:
  - `ld_ready`=0, `ld_done`=0, `ld_overflow`=0, `ld_count`=0.
  - `cpu_hold`=1, `instr`={0x10, 72'h0}.
  - `imem_error` follows `f_PC`.
- `ld_start` sampled at edge N: CLEAR runs edges N+1..N+`MEM_BYTES`; `ld_ready`=1 from the cycle after edge N+`MEM_BYTES`.
- Writes are visible on `instr` the cycle after the accepting edge.
- Last byte accepted at edge M: `cpu_hold` falls and `ld_done` rises after edge M; the core fetches from that cycle.
- `ld_ready` is state-only and never depends on `ld_valid`.

## Configuration
- `IMEM_NOP_PREFIX_EN` defined:
  - Address 0 is cleared to 0x10 (nop), and `BASE`=1.
  - The core skips its first fetch cycle on that nop.
  - Capacity is `MEM_BYTES`-1.
- `IMEM_NOP_PREFIX_EN` undefined:
  - Address 0 is cleared to 0x00, and `BASE`=0.
  - Capacity is `MEM_BYTES`.

## Structure
- Package `imem_pkg`:
  - state enum.
  - `NOP_BYTE`=8'h10, `HALT_BYTE`=8'h00.
  - `INSTR_BYTES` default.
- Sub-module `imem_byte_array`: byte storage with one write port and the `INSTR_BYTES`-wide read window with out-of-range zeroing.
- `imem_loader` holds the FSM, counters and the hold muxing.

## Test plan
- Reset:
  - Expect `cpu_hold`=1, `ld_ready`=0, `ld_done`=0, `instr`=80'h1000...0.
  - `f_PC`=300 -> `imem_error`=1.
- Load (macro on):
  - `ld_start`, then 256 CLEAR cycles, then bytes 30 F2 05 00 00 00 00 00 00 00 00 with `ld_last` on the 11th.
  - Expect `ld_count`=11 and `ld_done`=1.
  - `f_PC`=1 -> `instr`=30F20500000000000000; `f_PC`=0 -> `instr[79:72]`=0x10.
- Backpressure and gaps:
  - Random `ld_valid` deassertion during LOAD, plus `ld_valid` held during CLEAR.
  - Expect no byte accepted before `ld_ready`, and a contiguous image.
- Overflow (macro on):
  - Send 255 bytes without `ld_last`, then a 256th.
  - Expect `ld_overflow`=1, `ld_count`=255, `cpu_hold`=1.
  - Repeat with `ld_last` on byte 255 -> RUN.
- Window edge:
  - After a load filling 1..255 with 0xAA, set `f_PC`=250.
  - Expect `instr`=AAAAAAAAAAAA00000000 and `imem_error`=0.
  - `f_PC`=256 -> `imem_error`=1, `instr`=0.
- Reset mid-LOAD after 5 bytes:
  - Expect IDLE, hold=1, `ld_count`=0.
  - A new `ld_start` re-clears memory; an old byte at address 3 now reads 0x00 after load.
